// File: rtl/task_ctrl_unit.sv
// rtl/task_ctrl_unit.sv - per-task lifecycle, priority aging and budget control for the scheduler
module task_ctrl_unit #(
  parameter logic [3:0] TASK_ID      = 4'h9,
  parameter int         PRIO_W       = 8,
  parameter int         HIT_W        = 8,
  parameter int         HIT_INIT     = 128,
  parameter int         AGE_PERIOD   = 10000,
  parameter int         WAIT_TIMEOUT = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [15:0]         in_op,
  input  logic                op_valid,
  output logic [4+PRIO_W-1:0] out_sorter,
  output logic                out_valid,
  output logic [1:0]          state_o,
  output logic [HIT_W-1:0]    exe_hit_o
);

  typedef enum logic [1:0] {
    ST_READY = 2'b00,
    ST_SUSP  = 2'b01,
    ST_WAIT  = 2'b10,
    ST_TERM  = 2'b11
  } state_e;

  localparam int AGE_W  = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
  localparam int WAIT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam int PRIO_EXT_W = (PRIO_W > 4) ? PRIO_W : 4;
  localparam int HIT_EXT_W  = (HIT_W > 4) ? HIT_W : 4;

  localparam logic [AGE_W-1:0]  AGE_LAST  = AGE_W'(AGE_PERIOD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);
  localparam logic [PRIO_W-1:0] PRIO_MAX  = '1;

  state_e              state_q, state_d;
  logic [PRIO_W-1:0]   prio_q, prio_d;
  logic [HIT_W-1:0]    hit_q, hit_d;
  logic [AGE_W-1:0]    age_q, age_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic [3:0]          op_id;
  logic [3:0]          op_code;
  logic [3:0]          op_arg;
  logic                cmd_hit;
  logic                eligible;
  logic [PRIO_EXT_W-1:0] arg_prio;
  logic [HIT_EXT_W-1:0]  arg_hit;
  logic                unused_reserved;

  assign op_id    = in_op[11:8];
  assign op_code  = in_op[7:4];
  assign op_arg   = in_op[3:0];
  assign arg_prio = PRIO_EXT_W'(op_arg);
  assign arg_hit  = HIT_EXT_W'(op_arg);

  // Reserved opcode bits carry no meaning for this block.
  assign unused_reserved = ^in_op[15:12];

  // Commands are accepted for our id or the broadcast id; a terminated task ignores everything.
  assign cmd_hit  = op_valid && ((op_id == TASK_ID) || (op_id == 4'hF)) && (state_q != ST_TERM);
  assign eligible = (state_q == ST_READY) && (hit_q != '0);

  // Next-state: a command hit owns the cycle, so aging and the wait timeout only run on idle cycles.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    hit_d   = hit_q;
    age_d   = age_q;
    wait_d  = wait_q;
    if (cmd_hit) begin
      case (op_code)
        4'h1: begin
          state_d = ST_READY;
          wait_d  = '0;
        end
        4'h2: state_d = ST_SUSP;
        4'h3: begin
          state_d = ST_WAIT;
          wait_d  = '0;
        end
        4'h4, 4'hC: state_d = ST_TERM;
        4'h5: begin
          prio_d = arg_prio[PRIO_W-1:0];
          age_d  = '0;
        end
        4'h6: hit_d = arg_hit[HIT_W-1:0];
        4'h7, 4'hF: begin
          if (eligible) begin
            hit_d  = hit_q - HIT_W'(1);
            prio_d = '0;
            age_d  = '0;
          end
        end
        default: ;
      endcase
    end else begin
      if (state_q == ST_READY) begin
        if (age_q == AGE_LAST) begin
          age_d = '0;
          if (prio_q != PRIO_MAX) begin
            prio_d = prio_q + PRIO_W'(1);
          end
        end else begin
          age_d = age_q + AGE_W'(1);
        end
      end
      if ((WAIT_TIMEOUT > 0) && (state_q == ST_WAIT)) begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_READY;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
    end
  end

  // Task state registers; reset returns the task to a fresh READY with the initial budget.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_READY;
      prio_q  <= '0;
      hit_q   <= HIT_W'(HIT_INIT);
      age_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      hit_q   <= hit_d;
      age_q   <= age_d;
      wait_q  <= wait_d;
    end
  end

  assign out_valid  = eligible;
  assign out_sorter = eligible ? {TASK_ID, prio_q} : '0;
  assign state_o    = state_q;
  assign exe_hit_o  = hit_q;

endmodule

// File: tb/tb_task_ctrl_unit.sv
// tb/tb_task_ctrl_unit.sv - self-checking bench for task_ctrl_unit (default, fast-aging and timeout builds)
module tb_task_ctrl_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] in_op;
  logic        op_valid;

  logic [11:0] so_a, so_c;
  logic [5:0]  so_b;
  logic        ov_a, ov_b, ov_c;
  logic [1:0]  st_a, st_b, st_c;
  logic [7:0]  eh_a, eh_b, eh_c;

  always #5 CLK = ~CLK;

  task_ctrl_unit u_def (
    .CLK(CLK), .RST(RST), .in_op(in_op), .op_valid(op_valid),
    .out_sorter(so_a), .out_valid(ov_a), .state_o(st_a), .exe_hit_o(eh_a)
  );

  task_ctrl_unit #(.PRIO_W(2), .AGE_PERIOD(4)) u_age (
    .CLK(CLK), .RST(RST), .in_op(in_op), .op_valid(op_valid),
    .out_sorter(so_b), .out_valid(ov_b), .state_o(st_b), .exe_hit_o(eh_b)
  );

  task_ctrl_unit #(.WAIT_TIMEOUT(5)) u_wto (
    .CLK(CLK), .RST(RST), .in_op(in_op), .op_valid(op_valid),
    .out_sorter(so_c), .out_valid(ov_c), .state_o(st_c), .exe_hit_o(eh_c)
  );

  logic [31:0] obs_st[3], obs_hit[3], obs_val[3], obs_so[3];
  assign obs_st[0]  = {30'b0, st_a};
  assign obs_st[1]  = {30'b0, st_b};
  assign obs_st[2]  = {30'b0, st_c};
  assign obs_hit[0] = {24'b0, eh_a};
  assign obs_hit[1] = {24'b0, eh_b};
  assign obs_hit[2] = {24'b0, eh_c};
  assign obs_val[0] = {31'b0, ov_a};
  assign obs_val[1] = {31'b0, ov_b};
  assign obs_val[2] = {31'b0, ov_c};
  assign obs_so[0]  = {20'b0, so_a};
  assign obs_so[1]  = {26'b0, so_b};
  assign obs_so[2]  = {20'b0, so_c};

  int checks   = 0;
  int failures = 0;

  // Reference model: one record per instance, advanced once per clock from the task rules.
  int m_state[3], m_prio[3], m_hit[3], m_age[3], m_wait[3];
  int p_pw[3]  = '{8, 2, 8};
  int p_age[3] = '{10000, 4, 10000};
  int p_wto[3] = '{0, 0, 5};

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_state[k] = 0;
      m_prio[k]  = 0;
      m_hit[k]   = 128;
      m_age[k]   = 0;
      m_wait[k]  = 0;
    end
  endfunction

  function automatic void model_step(int k, logic [15:0] op, logic v);
    int id   = int'(op[11:8]);
    int opc  = int'(op[7:4]);
    int arg  = int'(op[3:0]);
    int pmax = (1 << p_pw[k]) - 1;
    if (v && (id == 9 || id == 15) && m_state[k] != 3) begin
      case (opc)
        1: begin m_state[k] = 0; m_wait[k] = 0; end
        2: m_state[k] = 1;
        3: begin m_state[k] = 2; m_wait[k] = 0; end
        4, 12: m_state[k] = 3;
        5: begin m_prio[k] = arg % (pmax + 1); m_age[k] = 0; end
        6: m_hit[k] = arg;
        7, 15: if (m_state[k] == 0 && m_hit[k] > 0) begin
          m_hit[k]  = m_hit[k] - 1;
          m_prio[k] = 0;
          m_age[k]  = 0;
        end
        default: ;
      endcase
    end else if (m_state[k] == 0) begin
      m_age[k] = m_age[k] + 1;
      if (m_age[k] == p_age[k]) begin
        m_age[k] = 0;
        if (m_prio[k] < pmax) m_prio[k] = m_prio[k] + 1;
      end
    end else if (m_state[k] == 2 && p_wto[k] > 0) begin
      m_wait[k] = m_wait[k] + 1;
      if (m_wait[k] == p_wto[k]) begin
        m_state[k] = 0;
        m_wait[k]  = 0;
      end
    end
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 3; k++) begin
      int v  = (m_state[k] == 0 && m_hit[k] != 0) ? 1 : 0;
      int so = (v != 0) ? ((9 << p_pw[k]) | m_prio[k]) : 0;
      check($sformatf("%s.u%0d.state", tag, k), obs_st[k], m_state[k]);
      check($sformatf("%s.u%0d.hit", tag, k), obs_hit[k], m_hit[k]);
      check($sformatf("%s.u%0d.valid", tag, k), obs_val[k], v);
      check($sformatf("%s.u%0d.sorter", tag, k), obs_so[k], so);
    end
  endtask

  task automatic tick(string tag);
    @(posedge CLK);
    for (int k = 0; k < 3; k++) model_step(k, in_op, op_valid);
    #1;
    check_all(tag);
  endtask

  task automatic drive(logic [15:0] op, logic v);
    in_op    = op;
    op_valid = v;
  endtask

  task automatic async_reset(string tag);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    RST = 1'b0;
  endtask

  initial begin
    RST      = 1'b1;
    in_op    = 16'h0000;
    op_valid = 1'b0;
    model_reset();
    #2;
    check_all("reset_hold");
    @(posedge CLK);
    #2;
    RST = 1'b0;

    for (int i = 0; i < 3; i++) tick("idle");
    check("tp1_sorter", obs_so[0], 32'h0900);
    check("tp1_hit", obs_hit[0], 32'd128);

    drive(16'h0953, 1'b1);
    tick("setprio");
    check("tp2_prio3", obs_so[0], 32'h0903);
    drive(16'h0970, 1'b1);
    tick("exec1");
    check("tp2_after_exec", obs_so[0], 32'h0900);
    check("tp2_hit127", obs_hit[0], 32'd127);

    drive(16'h0962, 1'b1);
    tick("sethits2");
    drive(16'h0970, 1'b1);
    tick("exec_a");
    check("tp3_hit1", obs_hit[0], 32'd1);
    tick("exec_b");
    check("tp3_hit0", obs_hit[0], 32'd0);
    tick("exec_c");
    check("tp3_hit_floor", obs_hit[0], 32'd0);
    check("tp3_valid0", obs_val[0], 32'd0);
    check("tp3_sorter0", obs_so[0], 32'd0);

    drive(16'h0000, 1'b0);
    async_reset("rst_age");
    for (int i = 1; i <= 20; i++) begin
      tick("aging");
      if (i == 4)  check("tp4_prio1", obs_so[1], 32'h25);
      if (i == 8)  check("tp4_prio2", obs_so[1], 32'h26);
      if (i == 12) check("tp4_prio3", obs_so[1], 32'h27);
    end
    check("tp4_saturated", obs_so[1], 32'h27);

    drive(16'h0930, 1'b1);
    tick("wait_enter");
    check("tp5_wait", obs_st[2], 32'd2);
    check("tp5_wait_invalid", obs_val[2], 32'd0);
    drive(16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) tick("wait_count");
    check("tp5_still_wait", obs_st[2], 32'd2);
    tick("wait_expire");
    check("tp5_timeout_ready", obs_st[2], 32'd0);

    drive(16'h0930, 1'b1);
    tick("wait_enter2");
    drive(16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) tick("wait_count2");
    drive(16'h0920, 1'b1);
    tick("suspend_beats_timeout");
    check("tp5_suspended", obs_st[2], 32'd1);
    drive(16'h0000, 1'b0);
    for (int i = 0; i < 8; i++) tick("susp_hold");
    check("tp5_no_autoreturn", obs_st[2], 32'd1);

    drive(16'h0910, 1'b1);
    tick("ready_again");
    drive(16'h0840, 1'b1);
    tick("other_id");
    check("tp6_other_id", obs_st[0], 32'd0);
    drive(16'h0940, 1'b0);
    tick("not_valid");
    check("tp6_not_valid", obs_st[0], 32'd0);
    drive(16'h0F40, 1'b1);
    tick("bcast_kill");
    check("tp6_killed", obs_st[1], 32'd3);
    drive(16'h0910, 1'b1);
    tick("kill_ignore1");
    drive(16'h0F10, 1'b1);
    tick("kill_ignore2");
    check("tp6_absorbing", obs_st[0], 32'd3);
    check("tp6_sorter0", obs_so[0], 32'd0);
    drive(16'h0000, 1'b0);
    async_reset("rst_mid");
    check("tp6_rst_state", obs_st[0], 32'd0);
    check("tp6_rst_sorter", obs_so[0], 32'h0900);

    for (int i = 0; i < 600; i++) begin
      logic [15:0] op;
      int sel;
      int opc;
      sel = $urandom_range(0, 3);
      opc = $urandom_range(0, 15);
      if ((opc == 4 || opc == 12) && $urandom_range(0, 7) != 0) opc = 1;
      op[15:12] = 4'($urandom_range(0, 15));
      op[11:8]  = (sel < 2) ? 4'h9 : (sel == 2) ? 4'hF : 4'($urandom_range(0, 15));
      op[7:4]   = 4'(opc);
      op[3:0]   = 4'($urandom_range(0, 15));
      drive(op, ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 59) == 0) async_reset("rand_rst");
      else tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
